stft_frame_binarizer: RTL

- Upstream loader for the BNN classifier.
- Accepts a stream of STFT magnitude samples and binarizes each one against a threshold latched at frame start.
- Packs the bits into 28-bit rows, writes 36 rows into MEM0 (addresses 0..35), then pulses start to the classifier.
- Waits for the classifier's class-index write to MEM0 address 36, captures it, and presents it to the host.

---
 rtl/stft_frame_binarizer_if.sv | 28 ++
 rtl/stft_frame_binarizer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stft_frame_binarizer_if.sv
// Sample stream, MEM0 write port and classifier result bus of the STFT frame binarizer.
// The slave modport is the binarizer's view; master is the surrounding system's view.
interface stft_frame_binarizer_if #(
    parameter int unsigned DW       = 16,
    parameter int unsigned ROW_BITS = 28,
    parameter int unsigned AW       = 6
);
    logic                iVALID;
    logic [DW-1:0]       iDATA;
    logic                oREADY;
    logic [AW-1:0]       oMEM0ADDR;
    logic [ROW_BITS-1:0] oMEM0WrDATA;
    logic                oMEM0Wr_EN;
    logic                oSTART;
    logic                iRESULT_EN;
    logic [AW-1:0]       iRESULT_ADDR;
    logic [ROW_BITS-1:0] iRESULT_DATA;

    modport slave (
        input  iVALID, iDATA, iRESULT_EN, iRESULT_ADDR, iRESULT_DATA,
        output oREADY, oMEM0ADDR, oMEM0WrDATA, oMEM0Wr_EN, oSTART
    );

    modport master (
        output iVALID, iDATA, iRESULT_EN, iRESULT_ADDR, iRESULT_DATA,
        input  oREADY, oMEM0ADDR, oMEM0WrDATA, oMEM0Wr_EN, oSTART
    );
endinterface

// File: rtl/stft_frame_binarizer.sv
// Binarizes STFT magnitudes against a per-frame threshold, packs them into MEM0 rows,
// kicks the BNN classifier and captures its class-index write back to the host.
module stft_frame_binarizer #(
    parameter int unsigned DW       = 16,
    parameter int unsigned ROW_BITS = 28,
    parameter int unsigned ROWS     = 36,
    parameter int unsigned AW       = 6
) (
    input  logic                      iCLK,
    input  logic                      iRSTn,
    input  logic                      iCLR,
    input  logic                      iGO,
    input  logic [DW-1:0]             iTHRESH,
    stft_frame_binarizer_if.slave     bus,
    output logic [3:0]                oCLASS,
    output logic                      oCLASS_VALID,
    output logic                      oBUSY
);

    typedef enum logic [2:0] {StIdle, StFill, StWrite, StStart, StWaitRes} state_e;

    state_e              r_state, w_state_nxt;
    logic [DW-1:0]       r_thr;
    logic [ROW_BITS-1:0] r_sr;
    logic [4:0]          r_bitcnt;
    logic [AW-1:0]       r_rowcnt;
    logic [AW-1:0]       r_addr;
    logic [ROW_BITS-1:0] r_wrdata;
    logic                r_wr_en;
    logic                r_start;
    logic [3:0]          r_class;
    logic                r_class_valid;

    logic                w_xfer;
    logic                w_bit;
    logic                w_row_done;
    logic                w_last_row;
    logic                w_res_hit;
    logic                w_unused_bits;

    assign w_xfer     = bus.iVALID && (r_state == StFill);
    assign w_bit      = (bus.iDATA >= r_thr);
    assign w_row_done = w_xfer && (r_bitcnt == 5'(ROW_BITS - 1));
    assign w_last_row = (r_rowcnt == AW'(ROWS - 1));
    assign w_res_hit  = (r_state == StWaitRes) && bus.iRESULT_EN &&
                        (bus.iRESULT_ADDR == AW'(ROWS));

    // Only the class index of the result word matters; the shift-out bit is dropped.
    assign w_unused_bits = ^{bus.iRESULT_DATA[ROW_BITS-1:4], r_sr[ROW_BITS-1]};

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:    if (iGO) w_state_nxt = StFill;
            StFill:    if (w_row_done) w_state_nxt = StWrite;
            StWrite:   w_state_nxt = w_last_row ? StStart : StFill;
            StStart:   w_state_nxt = StWaitRes;
            StWaitRes: if (w_res_hit) w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_state <= StIdle;
        end else if (iCLR) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            r_thr         <= '0;
            r_sr          <= '0;
            r_bitcnt      <= '0;
            r_rowcnt      <= '0;
            r_addr        <= '0;
            r_wrdata      <= '0;
            r_wr_en       <= 1'b0;
            r_start       <= 1'b0;
            r_class       <= '0;
            r_class_valid <= 1'b0;
        end else if (iCLR) begin
            r_thr         <= '0;
            r_sr          <= '0;
            r_bitcnt      <= '0;
            r_rowcnt      <= '0;
            r_addr        <= '0;
            r_wrdata      <= '0;
            r_wr_en       <= 1'b0;
            r_start       <= 1'b0;
            r_class       <= '0;
            r_class_valid <= 1'b0;
        end else begin
            // Strobes are registered so they line up with the WRITE/START state cycles.
            r_wr_en       <= w_row_done;
            r_start       <= (r_state == StWrite) && w_last_row;
            r_class_valid <= w_res_hit;

            if ((r_state == StIdle) && iGO) begin
                r_thr <= iTHRESH;
            end

            if (w_xfer) begin
                r_sr     <= {r_sr[ROW_BITS-2:0], w_bit};
                r_bitcnt <= w_row_done ? 5'd0 : r_bitcnt + 5'd1;
            end

            if (w_row_done) begin
                r_addr   <= r_rowcnt;
                r_wrdata <= {r_sr[ROW_BITS-2:0], w_bit};
            end

            if (r_state == StWrite) begin
                r_rowcnt <= w_last_row ? '0 : r_rowcnt + AW'(1);
            end

            if (w_res_hit) begin
                r_class <= bus.iRESULT_DATA[3:0];
            end
        end
    end

    assign bus.oREADY      = (r_state == StFill);
    assign bus.oMEM0ADDR   = r_addr;
    assign bus.oMEM0WrDATA = r_wrdata;
    assign bus.oMEM0Wr_EN  = r_wr_en;
    assign bus.oSTART      = r_start;
    assign oCLASS          = r_class;
    assign oCLASS_VALID    = r_class_valid;
    assign oBUSY           = (r_state != StIdle);

endmodule
